// File: rtl/cpu_sys_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit OCI DCT trace frames into 30-bit words, with valid/ready output and flush-to-end.
// Define CPU_SYS_DCT_DROP_CNT_EN to add the saturating dct_drop_count port.
module cpu_sys_nios2_qsys_0_oci_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    input  logic [1:0]  frame_data,
    input  logic        flush,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        overflow,
    output logic        test_ending,
    output logic        test_has_ended
`ifdef CPU_SYS_DCT_DROP_CNT_EN
    ,
    output logic [15:0] dct_drop_count
`endif
);
    logic [29:0] acc_q, acc_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        overflow_q, overflow_d;
    logic        ending_q, ending_d;
    logic        ended_q, ended_d;
    logic        free, xfer, take, drop;

    always_comb begin
        free       = !valid_q || dct_ready;
        xfer       = free && (acc_cnt_q == 4'd15 || (ending_q && acc_cnt_q != 4'd0));
        // take uses the registered ending flag so a frame coincident with flush is kept
        take       = frame_valid && !ending_q;
        drop       = !xfer && take && acc_cnt_q == 4'd15;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        overflow_d = drop;
        ending_d   = ending_q || flush;
        ended_d    = ended_q || (ending_q && acc_cnt_q == 4'd0 && !valid_q);
        if (xfer) begin
            buf_d   = acc_q;
            cnt_d   = acc_cnt_q;
            valid_d = 1'b1;
            if (take) begin
                acc_d     = {28'b0, frame_data};
                acc_cnt_d = 4'd1;
            end else begin
                acc_d     = '0;
                acc_cnt_d = 4'd0;
            end
        end else begin
            if (take && acc_cnt_q != 4'd15) begin
                acc_d     = {acc_q[27:0], frame_data};
                acc_cnt_d = acc_cnt_q + 4'd1;
            end
            if (valid_q && dct_ready) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            ending_q   <= 1'b0;
            ended_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            ending_q   <= ending_d;
            ended_q    <= ended_d;
        end
    end

`ifdef CPU_SYS_DCT_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign dct_drop_count = drop_cnt_q;
`endif

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign dct_valid      = valid_q;
    assign overflow       = overflow_q;
    assign test_ending    = ending_q;
    assign test_has_ended = ended_q;
endmodule

// File: tb/tb_cpu_sys_nios2_qsys_0_oci_dct_packer.sv
// Directed + random bench for the DCT packer against a queue-based reference model.
module tb_cpu_sys_nios2_qsys_0_oci_dct_packer;
    logic        clk = 1'b0;
    logic        rst_n, fv, fl, rdy;
    logic [1:0]  fd;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid, overflow, test_ending, test_has_ended;
`ifdef CPU_SYS_DCT_DROP_CNT_EN
    logic [15:0] dct_drop_count;
`endif

    cpu_sys_nios2_qsys_0_oci_dct_packer dut (
        .clk(clk), .reset_n(rst_n), .frame_valid(fv), .frame_data(fd), .flush(fl),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .dct_ready(rdy), .overflow(overflow), .test_ending(test_ending),
        .test_has_ended(test_has_ended)
`ifdef CPU_SYS_DCT_DROP_CNT_EN
        , .dct_drop_count(dct_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int words = 0;
    int ovfs = 0;
    logic [29:0] last_word;
    logic [3:0]  last_cnt;

    // reference model: pending frames kept as a queue, packed only when a word is emitted
    logic [1:0]  mq[$];
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    logic        m_valid, m_ovf, m_te, m_the;
    int          m_drop;

    function automatic logic [29:0] pack(input logic [1:0] q[$]);
        logic [29:0] w;
        w = '0;
        foreach (q[i]) w = {w[27:0], q[i]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int sz;
        bit free, xfer, take, ended_now;
        sz        = mq.size();
        free      = !m_valid || rdy;
        xfer      = free && (sz == 15 || (m_te && sz != 0));
        take      = fv && !m_te;
        ended_now = m_te && sz == 0 && !m_valid;
        if (dct_valid && rdy) begin
            words++;
            last_word = dct_buffer;
            last_cnt  = dct_count;
        end
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_buf = '0; m_cnt = '0; m_valid = 0; m_ovf = 0; m_te = 0; m_the = 0; m_drop = 0;
        end else begin
            m_the = m_the || ended_now;
            m_te  = m_te || fl;
            m_ovf = 0;
            if (xfer) begin
                m_buf   = pack(mq);
                m_cnt   = 4'(sz);
                m_valid = 1;
                mq.delete();
                if (take) mq.push_back(fd);
            end else begin
                if (take && sz < 15) mq.push_back(fd);
                else if (take) begin
                    m_ovf = 1;
                    if (m_drop < 16'hFFFF) m_drop++;
                end
                if (m_valid && rdy) m_valid = 0;
            end
        end
        #1;
        chk("buffer", 32'(dct_buffer), 32'(m_buf));
        chk("count", 32'(dct_count), 32'(m_cnt));
        chk("valid", 32'(dct_valid), 32'(m_valid));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("test_ending", 32'(test_ending), 32'(m_te));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_the));
`ifdef CPU_SYS_DCT_DROP_CNT_EN
        chk("drop_count", 32'(dct_drop_count), 32'(m_drop));
`endif
        if (overflow) ovfs++;
        fv = 0; fl = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; fv = 0; fl = 0;
        step();
        rst_n = 1;
    endtask

    logic [1:0]  frames[31];
    logic [29:0] exp_w;
    logic [29:0] held;
    int          w0, o0;

    initial begin
        rst_n = 0; fv = 0; fd = 0; fl = 0; rdy = 1;
        mq.delete();
        m_buf = '0; m_cnt = '0; m_valid = 0; m_ovf = 0; m_te = 0; m_the = 0; m_drop = 0;
        do_reset();
        chk("reset_buffer", 32'(dct_buffer), 32'h0);
        chk("reset_valid", 32'(dct_valid), 32'h0);
        chk("reset_ended", 32'(test_has_ended), 32'h0);

        // 15 frames of 01 -> one full word two cycles after the last frame
        rdy = 1;
        for (int i = 0; i < 15; i++) begin fv = 1; fd = 2'b01; step(); end
        step();
        chk("t1_word", 32'(dct_buffer), 32'h15555555);
        chk("t1_count", 32'(dct_count), 32'd15);
        chk("t1_valid", 32'(dct_valid), 32'd1);
        step();
        chk("t1_valid_drop", 32'(dct_valid), 32'd0);

        // 30 frames cycling 0..3 at full rate
        do_reset();
        w0 = words; o0 = ovfs;
        for (int i = 0; i < 30; i++) begin fv = 1; fd = 2'(i % 4); step(); end
        for (int i = 0; i < 4; i++) step();
        chk("t2_words", words - w0, 2);
        chk("t2_ovf", ovfs - o0, 0);
        chk("t2_last_cnt", 32'(last_cnt), 32'd15);

        // sink stalled: 31 frames, last one dropped
        do_reset();
        rdy = 0; w0 = words; o0 = ovfs;
        for (int i = 0; i < 31; i++) frames[i] = 2'($urandom_range(0, 3));
        exp_w = '0;
        for (int i = 0; i < 15; i++) exp_w = {exp_w[27:0], frames[i]};
        for (int i = 0; i < 31; i++) begin
            fv = 1; fd = frames[i]; step();
            if (i == 16) held = dct_buffer;
        end
        chk("t3_held_first", 32'(held), 32'(exp_w));
        chk("t3_still_held", 32'(dct_buffer), 32'(exp_w));
        chk("t3_ovf_pulse", 32'(overflow), 32'd1);
        step();
        chk("t3_ovf_once", ovfs - o0, 1);
        rdy = 1;
        for (int i = 0; i < 4; i++) step();
        chk("t3_words", words - w0, 2);
        exp_w = '0;
        for (int i = 15; i < 30; i++) exp_w = {exp_w[27:0], frames[i]};
        chk("t3_second", 32'(last_word), 32'(exp_w));

        // 3,2,1 then flush -> partial word 0x39
        do_reset();
        w0 = words;
        fv = 1; fd = 2'd3; step();
        fv = 1; fd = 2'd2; step();
        fv = 1; fd = 2'd1; step();
        fl = 1; step();
        chk("t4_ending", 32'(test_ending), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("t4_word", 32'(last_word), 32'h39);
        chk("t4_cnt", 32'(last_cnt), 32'd3);
        chk("t4_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 20; i++) begin fv = 1; fd = 2'd2; step(); end
        chk("t4_ignored", words - w0, 1);

        // flush while empty
        do_reset();
        w0 = words;
        fl = 1; step();
        chk("t5_ending", 32'(test_ending), 32'd1);
        chk("t5_not_yet", 32'(test_has_ended), 32'd0);
        step();
        chk("t5_ended", 32'(test_has_ended), 32'd1);
        step();
        chk("t5_no_word", words - w0, 0);

        // reset mid-operation discards partial and pending words
        do_reset();
        rdy = 0;
        for (int i = 0; i < 22; i++) begin fv = 1; fd = 2'($urandom_range(0, 3)); step(); end
        chk("t6_pending", 32'(dct_valid), 32'd1);
        do_reset();
        chk("t6_buf0", 32'(dct_buffer), 32'h0);
        chk("t6_cnt0", 32'(dct_count), 32'h0);
        chk("t6_valid0", 32'(dct_valid), 32'h0);
        rdy = 1; w0 = words;
        fl = 1; step();
        for (int i = 0; i < 4; i++) step();
        chk("t6_no_word", words - w0, 0);
        chk("t6_ended", 32'(test_has_ended), 32'd1);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            fv    = ($urandom_range(0, 3) != 0);
            fd    = 2'($urandom_range(0, 3));
            rdy   = ($urandom_range(0, 9) < 6);
            fl    = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_sys_nios2_qsys_0_oci_dct_packer.md
# cpu_sys_nios2_qsys_0_oci_dct_packer

Packs the Nios II OCI data-capture trace (DCT) stream of 2-bit frames into 30-bit words. Produces the `dct_buffer`/`dct_count` pair, plus the `test_ending`/`test_has_ended` status, that the OCI test bench consumes. Sits between the OCI trace-frame source and the trace sink, with a valid/ready output handshake and a flush-to-end sequence.

## Interface
Parameters: none (geometry fixed: 15 slots × 2 bits = 30 bits).

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  reset; synchronous, active-low
- `frame_valid`  in  1  `frame_data` valid this cycle
- `frame_data`  in  2  one DCT frame
- `flush`  in  1  one-cycle pulse; drain partial word and end trace
- `dct_buffer`  out  30  packed word; newest frame in [1:0]
- `dct_count`  out  4  number of valid frames in `dct_buffer`, 1..15
- `dct_valid`  out  1  output word valid
- `dct_ready`  in  1  sink accepts word when `dct_valid & dct_ready`
- `overflow`  out  1  one-cycle pulse per dropped frame
- `test_ending`  out  1  sticky; flush requested
- `test_has_ended`  out  1  sticky; flush complete, all data drained
- `dct_drop_count`  out  16  saturating drop counter (only with `CPU_SYS_DCT_DROP_CNT_EN`)

## Operation
- Internal accumulator `acc[29:0]` and `acc_cnt[3:0]` (0..15); output holding register `dct_buffer`/`dct_count`/`dct_valid`.
- `free = !dct_valid | dct_ready`.
- `xfer = free & (acc_cnt==15 | (test_ending & acc_cnt!=0))`.
- `take = frame_valid & !test_ending`.
- On `xfer`:
  - Output register ← `{acc, acc_cnt}`, `dct_valid` ← 1.
  - If `take`: acc ← `{28'b0, frame_data}`, `acc_cnt` ← 1.
  - Otherwise: acc ← 0, `acc_cnt` ← 0.
- If `!xfer & take & acc_cnt<15`: acc ← `{acc[27:0], frame_data}`, `acc_cnt`+1.
- If `!xfer & take & acc_cnt==15`: frame dropped, `overflow` pulses next cycle, acc unchanged.
- If `!xfer & dct_valid & dct_ready`: `dct_valid` ← 0.
- Partial word with count k: valid frames occupy [2k-1:0], oldest at [2k-1:2k-2]; bits above are 0.
- Flush sequence:
  - `flush` sets `test_ending`, sticky until reset.
  - While `test_ending`, frames are ignored. They are not counted as overflow.
  - `test_has_ended` sets when `test_ending & acc_cnt==0 & !dct_valid`, sticky until reset.
  - Further `flush` pulses have no effect.
- `flush` coincident with `frame_valid`: that frame is accepted (`take` uses the registered `test_ending`).
- Reset values: `dct_buffer`=0, `dct_count`=0, `dct_valid`=0, `overflow`=0, `test_ending`=0, `test_has_ended`=0, `dct_drop_count`=0; acc and `acc_cnt` also cleared. Reset mid-operation discards partial and pending words.

## Timing
- 15th frame at edge N → `acc_cnt`=15 at N+1 → `dct_valid`=1 at N+2 if `free` at N+1.
- Full-rate input with `dct_ready`=1: no drops. Frame 16 at N+1 lands in the cleared accumulator, giving one word per 15 frames.
- `dct_ready`=0 holds `dct_buffer`/`dct_count` stable. The accumulator fills to 15, then drops frames.
- `flush` at N → `test_ending`=1 at N+1. If empty: `test_has_ended`=1 at N+2.
- `overflow` is registered, 1 cycle after the dropped frame.

## Configuration
- `CPU_SYS_DCT_DROP_CNT_EN` defined: `dct_drop_count` port exists. It increments on each dropped frame, saturates at 16'hFFFF, and is cleared only by reset.
- Not defined: port and counter absent. `overflow` pulse is still produced.

## Test plan
- Reset, then 15 frames of 2'b01 back-to-back with `dct_ready`=1 → one word `dct_buffer`=30'h15555555, `dct_count`=15, `dct_valid` high 1 cycle, 2 cycles after last frame.
- 30 consecutive frames cycling 0,1,2,3 with `dct_ready`=1 → exactly two words, each `dct_count`=15, no `overflow`; first word = 30'h06C6C6C6 (frames 0..14 = 0,1,2,3,…,0,1,2).
- `dct_ready`=0, 31 frames → first word held stable; accumulator full at 15; frame 31 dropped, `overflow` 1 pulse; `dct_drop_count`=1 if enabled. Then raise ready → two words delivered.
- 3 frames 3,2,1 then `flush` → word `dct_buffer`=30'h39, `dct_count`=3. `test_ending` 1 cycle after flush, `test_has_ended` after the word is accepted. Later frames are ignored.
- `flush` with empty block → `test_ending` at +1, `test_has_ended` at +2, no word emitted.
- `reset_n` low for 1 cycle with 7 frames accumulated and a word pending under `dct_ready`=0 → all outputs 0 next cycle; a following `flush` produces no word.
